// File: rtl/axi_grid_xni_vc_egress.sv
// Grid NI egress: per-VC flit FIFOs with downstream credit counters, round-robin
// multiplexed onto one registered outbound link.

package axi_default_param_pkg;
  typedef logic [7:0] grid_id_t;
endpackage

module axi_grid_xni_vc_egress_lane #(
  parameter int DEPTH   = 4,
  parameter int FLIT_W  = 64,
  parameter int CREDITS = 4,
  parameter bit OVF_CHK = 1'b1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_valid_i,
  input  logic [FLIT_W:0]   wr_data_i,
  output logic              wr_ready_o,
  input  logic              pop_i,
  input  logic              credit_i,
  output logic [FLIT_W:0]   head_o,
  output logic              empty_o,
  output logic              eligible_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(CREDITS + 1);

  logic [DEPTH-1:0][FLIT_W:0] mem_q, mem_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [RW-1:0]              cred_q, cred_d;
  logic                       full, push, pop;

  always_comb begin
    full       = (cnt_q == CW'(DEPTH));
    empty_o    = (cnt_q == '0);
    // Ready depends on fullness only: a same-cycle pop does not free a slot.
    wr_ready_o = !full && !srst_i;
    eligible_o = !empty_o && (cred_q != '0);
    head_o     = mem_q[rd_ptr_q];
    push       = wr_valid_i && wr_ready_o;
    pop        = pop_i && eligible_o;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    cred_d   = cred_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Grant and returned credit in the same cycle cancel; saturate at CREDITS.
    if (pop && !credit_i)
      cred_d = cred_q - RW'(1);
    else if (!pop && credit_i && (cred_q != RW'(CREDITS)))
      cred_d = cred_q + RW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      cred_q   <= RW'(CREDITS);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      cred_q   <= cred_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (OVF_CHK && !srst_i && credit_i && !pop)
      assert (cred_q != RW'(CREDITS)) else $error("credit returned while counter full");
  end
endmodule

module axi_grid_xni_vc_egress #(
  parameter int  NUM_VC         = 4,
  parameter int  DEPTH          = 4,
  parameter int  FLIT_W         = 64,
  parameter int  CREDITS        = 4,
  parameter type grid_id_t      = axi_default_param_pkg::grid_id_t,
  parameter grid_id_t NI_ID     = '0,
  parameter bit  CREDIT_OVF_CHK = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           srst_i,
  input  logic [NUM_VC-1:0]              in_valid_i,
  output logic [NUM_VC-1:0]              in_ready_o,
  input  logic [NUM_VC-1:0][FLIT_W-1:0]  in_flit_i,
  input  logic [NUM_VC-1:0]              in_last_i,
  input  logic [NUM_VC-1:0]              credit_i,
  output logic                           out_valid_o,
  output logic [FLIT_W-1:0]              out_flit_o,
  output logic [$clog2(NUM_VC)-1:0]      out_vc_o,
  output logic                           out_last_o,
  output grid_id_t                       src_id_o,
  output logic                           idle_o
);
  localparam int VC_W = $clog2(NUM_VC);

  logic [NUM_VC-1:0][FLIT_W:0] head;
  logic [NUM_VC-1:0]           empty, elig, pop;
  logic                        gnt_vld;
  logic [VC_W-1:0]             gnt_idx, cand;

  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic [VC_W-1:0]   out_vc_q, out_vc_d;
  logic              out_last_q, out_last_d;
  logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_lane
    assign pop[v] = gnt_vld && (gnt_idx == VC_W'(v));
    axi_grid_xni_vc_egress_lane #(
      .DEPTH   (DEPTH),
      .FLIT_W  (FLIT_W),
      .CREDITS (CREDITS),
      .OVF_CHK (CREDIT_OVF_CHK)
    ) u_lane (
      .clk_i      (clk_i),
      .srst_i     (srst_i),
      .wr_valid_i (in_valid_i[v]),
      .wr_data_i  ({in_last_i[v], in_flit_i[v]}),
      .wr_ready_o (in_ready_o[v]),
      .pop_i      (pop[v]),
      .credit_i   (credit_i[v]),
      .head_o     (head[v]),
      .empty_o    (empty[v]),
      .eligible_o (elig[v])
    );
  end

  // Search starts one past the last granted VC so every VC gets a turn.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_VC; i++) begin
      cand = VC_W'((int'(rr_ptr_q) + i) % NUM_VC);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    out_valid_d = gnt_vld;
    out_flit_d  = out_flit_q;
    out_vc_d    = out_vc_q;
    out_last_d  = out_last_q;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_vld) begin
      {out_last_d, out_flit_d} = head[gnt_idx];
      out_vc_d = gnt_idx;
      rr_ptr_d = gnt_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_vc_q    <= '0;
      out_last_q  <= 1'b0;
      rr_ptr_q    <= VC_W'(NUM_VC - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_vc_q    <= out_vc_d;
      out_last_q  <= out_last_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_flit_o  = out_flit_q;
  assign out_vc_o    = out_vc_q;
  assign out_last_o  = out_last_q;
  assign src_id_o    = NI_ID;
  assign idle_o      = (&empty) && !out_valid_q;
endmodule

// File: tb/tb_axi_grid_xni_vc_egress.sv
// Bench for the grid NI egress: directed scenarios plus random traffic, checked
// against a queue-based model of FIFOs, credits and round-robin selection.

module tb_axi_grid_xni_vc_egress;
  localparam int NV = 4;
  localparam int DP = 4;
  localparam int FW = 64;
  localparam int CR = 4;
  localparam axi_default_param_pkg::grid_id_t NID = 8'h5A;

  logic                   clk = 1'b0;
  logic                   srst;
  logic [NV-1:0]          in_valid, in_ready, in_last, credit;
  logic [NV-1:0][FW-1:0]  in_flit;
  logic                   out_valid, out_last, idle;
  logic [FW-1:0]          out_flit;
  logic [1:0]             out_vc;
  axi_default_param_pkg::grid_id_t src_id;

  always #5 clk = ~clk;

  axi_grid_xni_vc_egress #(
    .NUM_VC(NV), .DEPTH(DP), .FLIT_W(FW), .CREDITS(CR),
    .NI_ID(NID), .CREDIT_OVF_CHK(1'b0)
  ) dut (
    .clk_i(clk), .srst_i(srst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_flit_i(in_flit),
    .in_last_i(in_last), .credit_i(credit),
    .out_valid_o(out_valid), .out_flit_o(out_flit), .out_vc_o(out_vc),
    .out_last_o(out_last), .src_id_o(src_id), .idle_o(idle)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [FW:0]   q [NV][$];
  int            cred [NV];
  int            rr;
  logic          m_vld, m_last;
  logic [FW-1:0] m_flit;
  int            m_vc;

  int obs_cnt [NV];
  int cyc;
  int vc_log[$];
  int cyc_log[$];

  logic [NV-1:0]         sv, sl, sc;
  logic [NV-1:0][FW-1:0] sf;
  int                    base;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      q[i].delete();
      cred[i] = CR;
    end
    rr = NV - 1; m_vld = 1'b0; m_flit = '0; m_vc = 0; m_last = 1'b0;
  endtask

  // One clock: drive at negedge, check DUT against model, advance model.
  task automatic cycle(input logic rst, input logic [NV-1:0] v, input logic [NV-1:0] l,
                       input logic [NV-1:0] c, input logic [NV-1:0][FW-1:0] f);
    int g;
    logic [NV-1:0] acc;
    logic all_empty;
    srst = rst; in_valid = v; in_last = l; credit = c; in_flit = f;
    #1;
    all_empty = 1'b1;
    for (int i = 0; i < NV; i++) if (q[i].size() != 0) all_empty = 1'b0;
    chk("out_valid", out_valid, m_vld);
    if (m_vld) begin
      chk("out_flit", out_flit, m_flit);
      chk("out_vc", out_vc, m_vc[1:0]);
      chk("out_last", out_last, m_last);
    end
    if (out_valid === 1'b1) begin
      obs_cnt[out_vc]++;
      vc_log.push_back(int'(out_vc));
      cyc_log.push_back(cyc);
    end
    chk("idle", idle, all_empty && !m_vld);
    for (int i = 0; i < NV; i++)
      chk($sformatf("in_ready%0d", i), in_ready[i], !rst && (q[i].size() < DP));

    if (rst) begin
      model_reset();
    end else begin
      g = -1;
      for (int k = 1; k <= NV; k++) begin
        int idx;
        idx = (rr + k) % NV;
        if (g < 0 && q[idx].size() > 0 && cred[idx] > 0) g = idx;
      end
      for (int i = 0; i < NV; i++) acc[i] = v[i] && (q[i].size() < DP);
      if (g >= 0) begin
        logic [FW:0] h;
        h = q[g].pop_front();
        m_vld = 1'b1; m_last = h[FW]; m_flit = h[FW-1:0]; m_vc = g; rr = g;
      end else begin
        m_vld = 1'b0;
      end
      for (int i = 0; i < NV; i++) begin
        cred[i] = cred[i] + int'(c[i]) - ((g == i) ? 1 : 0);
        if (cred[i] > CR) cred[i] = CR;
        if (acc[i]) q[i].push_back({l[i], f[i]});
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    cycle(1'b1, '0, '0, '0, '0);
    cycle(1'b1, '0, '0, '0, '0);
  endtask

  task automatic push1(input int vc, input logic [NV-1:0] c);
    logic [NV-1:0][FW-1:0] f;
    f = '0;
    f[vc] = {$urandom, $urandom};
    cycle(1'b0, NV'(1) << vc, NV'($urandom), c, f);
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < NV; i++) obs_cnt[i] = 0;
    srst = 1'b1; in_valid = '0; in_last = '0; credit = '0; in_flit = '0;
    @(negedge clk); @(negedge clk);
    model_reset();
    do_reset();
    chk("rst_flit", out_flit, 0);
    chk("rst_vc", out_vc, 0);
    chk("rst_last", out_last, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ready", in_ready, 0);
    chk("src_id", src_id, NID);

    // single flit latency on VC2
    sf = '0; sf[2] = 64'hA5;
    cycle(1'b0, 4'b0100, 4'b0100, '0, sf);
    idle_n(1);
    chk("t1_vld", out_valid, 1);
    chk("t1_vc", out_vc, 2);
    chk("t1_flit", out_flit, 64'hA5);
    chk("t1_last", out_last, 1);
    idle_n(1);
    chk("t1_idle", idle, 1);

    // all VCs busy: strict rotation, no gaps
    do_reset();
    vc_log.delete(); cyc_log.delete();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NV; i++) sf[i] = {$urandom, $urandom};
      cycle(1'b0, 4'hF, 4'($urandom), '0, sf);
    end
    idle_n(14);
    chk("t2_cnt", vc_log.size(), 12);
    for (int i = 0; i < vc_log.size() && i < 12; i++)
      chk($sformatf("t2_order%0d", i), vc_log[i], i % NV);
    if (cyc_log.size() >= 12) chk("t2_gap", cyc_log[11] - cyc_log[0], 11);

    // VC1 limited by credits
    do_reset();
    base = obs_cnt[1];
    for (int n = 0; n < 5; n++) push1(1, '0);
    idle_n(6);
    chk("t3_burst", obs_cnt[1] - base, CR);
    base = obs_cnt[1];
    cycle(1'b0, '0, '0, 4'b0010, '0);
    idle_n(4);
    chk("t3_credit", obs_cnt[1] - base, 1);

    // VC0 fills with no credits, then one credit frees a slot
    do_reset();
    for (int n = 0; n < 4; n++) push1(0, '0);
    idle_n(4);
    for (int n = 0; n < 4; n++) push1(0, '0);
    chk("t4_full", in_ready[0], 0);
    cycle(1'b0, '0, '0, 4'b0001, '0);
    idle_n(1);
    chk("t4_free", in_ready[0], 1);
    idle_n(2);

    // credit on VC3 in the grant cycle leaves the count unchanged
    do_reset();
    base = obs_cnt[3];
    push1(3, '0);
    push1(3, 4'b1000);
    for (int n = 0; n < 4; n++) push1(3, '0);
    idle_n(8);
    chk("t5_cancel", obs_cnt[3] - base, CR + 1);

    // credit at full count saturates
    do_reset();
    cycle(1'b0, '0, '0, 4'hF, '0);
    base = obs_cnt[2];
    for (int n = 0; n < 6; n++) push1(2, '0);
    idle_n(8);
    chk("t5_sat", obs_cnt[2] - base, CR);

    // reset with traffic queued on every VC
    do_reset();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NV; i++) sf[i] = {$urandom, $urandom};
      cycle(1'b0, 4'hF, 4'hF, '0, sf);
    end
    cycle(1'b1, '0, '0, '0, '0);
    chk("t6_vld", out_valid, 0);
    chk("t6_idle", idle, 1);
    base = obs_cnt[1];
    for (int n = 0; n < 6; n++) push1(1, '0);
    idle_n(8);
    chk("t6_cred", obs_cnt[1] - base, CR);

    // random traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      sv = NV'($urandom); sl = NV'($urandom); sc = '0;
      for (int i = 0; i < NV; i++) begin
        sf[i] = {$urandom, $urandom};
        if (cred[i] < CR) sc[i] = ($urandom_range(0, 2) == 0);
        else              sc[i] = ($urandom_range(0, 49) == 0);
      end
      cycle($urandom_range(0, 299) == 0, sv, sl, sc, sf);
    end
    idle_n(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
